// File: rtl/acc_dma_csr.sv
// acc_dma_csr: CPU-facing MMIO control/status block for the duplex AXIS DMA.
//
// What it does:
//   Decodes 64-bit CPU load/store requests and holds the rx source address,
//   the tx destination address and both packet counts. It issues one-cycle
//   start strobes, captures DMA done pulses as sticky status bits, and drives
//   a level interrupt.
//
// Ports:
//   clk, rstn                  clock, synchronous active-low reset
//   csr_req_*                  CPU request (ready tied high)
//   csr_rsp_valid/rdata        registered response, one cycle after acceptance
//   dma_rx_src/len/start       rx engine configuration and start strobe
//   dma_rx_busy/done           rx engine status inputs
//   dma_tx_dst/len/start       tx engine configuration and start strobe
//   dma_tx_busy/done           tx engine status inputs
//   irq                        level interrupt
//
// Build option:
//   DMA_CSR_PERF_EN adds the PERF_RX (0x30) and PERF_TX (0x38) busy-cycle
//   counters. Without it those offsets behave as unmapped.
//
// Register map (byte offsets):
//   0x00 CTRL    b0 start_rx (W1S), b1 start_tx (W1S), b8 irq_en (RW)
//   0x08 SRC_RX  0x10 DST_TX  0x18 LEN_RX  0x20 LEN_TX
//   0x28 STATUS  b0 busy_rx, b1 done_rx, b2 busy_tx, b3 done_tx, b4 err_rx, b5 err_tx
module acc_dma_csr #(
    parameter int ADDR_W = 6,
    parameter int LEN_W  = 32,
    parameter int DATA_W = 64
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              csr_req_valid,
    output logic              csr_req_ready,
    input  logic              csr_req_we,
    input  logic [ADDR_W-1:0] csr_req_addr,
    input  logic [DATA_W-1:0] csr_req_wdata,
    output logic              csr_rsp_valid,
    output logic [DATA_W-1:0] csr_rsp_rdata,
    output logic [63:0]       dma_rx_src,
    output logic [LEN_W-1:0]  dma_rx_len,
    output logic              dma_rx_start,
    input  logic              dma_rx_busy,
    input  logic              dma_rx_done,
    output logic [63:0]       dma_tx_dst,
    output logic [LEN_W-1:0]  dma_tx_len,
    output logic              dma_tx_start,
    input  logic              dma_tx_busy,
    input  logic              dma_tx_done,
    output logic              irq
);

    localparam logic [ADDR_W-1:0] A_CTRL   = ADDR_W'('h00);
    localparam logic [ADDR_W-1:0] A_SRC_RX = ADDR_W'('h08);
    localparam logic [ADDR_W-1:0] A_DST_TX = ADDR_W'('h10);
    localparam logic [ADDR_W-1:0] A_LEN_RX = ADDR_W'('h18);
    localparam logic [ADDR_W-1:0] A_LEN_TX = ADDR_W'('h20);
    localparam logic [ADDR_W-1:0] A_STATUS = ADDR_W'('h28);
`ifdef DMA_CSR_PERF_EN
    localparam logic [ADDR_W-1:0] A_PERF_RX = ADDR_W'('h30);
    localparam logic [ADDR_W-1:0] A_PERF_TX = ADDR_W'('h38);
`endif

    logic [63:0]       src_rx_q, src_rx_d;
    logic [63:0]       dst_tx_q, dst_tx_d;
    logic [LEN_W-1:0]  len_rx_q, len_rx_d;
    logic [LEN_W-1:0]  len_tx_q, len_tx_d;
    logic              irq_en_q, irq_en_d;
    logic              rx_start_q, rx_start_d;
    logic              tx_start_q, tx_start_d;
    logic              done_rx_q, done_rx_d;
    logic              done_tx_q, done_tx_d;
    logic              err_rx_q, err_rx_d;
    logic              err_tx_q, err_tx_d;
    logic              irq_q, irq_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;

    logic wr, rd;
    logic lock_rx, lock_tx;
    logic err_rx_set, err_tx_set;
    logic done_rx_clr, done_tx_clr, err_rx_clr, err_tx_clr;

`ifdef DMA_CSR_PERF_EN
    logic [63:0] perf_rx_q, perf_rx_d;
    logic [63:0] perf_tx_q, perf_tx_d;
`endif

    assign wr = csr_req_valid & csr_req_we;
    assign rd = csr_req_valid & ~csr_req_we;

    // Configuration is frozen while the engine runs and during the cycle its
    // start strobe is on the wire, so the engine never sees a torn setup.
    assign lock_rx = dma_rx_busy | rx_start_q;
    assign lock_tx = dma_tx_busy | tx_start_q;

    always_comb begin
        src_rx_d    = src_rx_q;
        dst_tx_d    = dst_tx_q;
        len_rx_d    = len_rx_q;
        len_tx_d    = len_tx_q;
        irq_en_d    = irq_en_q;
        rx_start_d  = 1'b0;
        tx_start_d  = 1'b0;
        err_rx_set  = 1'b0;
        err_tx_set  = 1'b0;
        done_rx_clr = 1'b0;
        done_tx_clr = 1'b0;
        err_rx_clr  = 1'b0;
        err_tx_clr  = 1'b0;

        if (wr) begin
            case (csr_req_addr)
                A_CTRL: begin
                    irq_en_d = csr_req_wdata[8];
                    if (csr_req_wdata[0]) begin
                        if (!dma_rx_busy && len_rx_q != '0) rx_start_d = 1'b1;
                        else                                err_rx_set = 1'b1;
                    end
                    if (csr_req_wdata[1]) begin
                        if (!dma_tx_busy && len_tx_q != '0) tx_start_d = 1'b1;
                        else                                err_tx_set = 1'b1;
                    end
                end
                A_SRC_RX: begin
                    if (lock_rx) err_rx_set = 1'b1;
                    else         src_rx_d   = csr_req_wdata;
                end
                A_LEN_RX: begin
                    if (lock_rx) err_rx_set = 1'b1;
                    else         len_rx_d   = csr_req_wdata[LEN_W-1:0];
                end
                A_DST_TX: begin
                    if (lock_tx) err_tx_set = 1'b1;
                    else         dst_tx_d   = csr_req_wdata;
                end
                A_LEN_TX: begin
                    if (lock_tx) err_tx_set = 1'b1;
                    else         len_tx_d   = csr_req_wdata[LEN_W-1:0];
                end
                A_STATUS: begin
                    done_rx_clr = csr_req_wdata[1];
                    done_tx_clr = csr_req_wdata[3];
                    err_rx_clr  = csr_req_wdata[4];
                    err_tx_clr  = csr_req_wdata[5];
                end
                default: ;
            endcase
        end

        // Set beats clear: an event arriving with a W1C is never lost.
        done_rx_d = (done_rx_q & ~done_rx_clr) | dma_rx_done;
        done_tx_d = (done_tx_q & ~done_tx_clr) | dma_tx_done;
        err_rx_d  = (err_rx_q  & ~err_rx_clr)  | err_rx_set;
        err_tx_d  = (err_tx_q  & ~err_tx_clr)  | err_tx_set;

        irq_d = irq_en_q & (done_rx_q | done_tx_q | err_rx_q | err_tx_q);

        rsp_valid_d = csr_req_valid;
        rdata_d     = '0;
        if (rd) begin
            case (csr_req_addr)
                A_CTRL:    rdata_d = DATA_W'({irq_en_q, 8'b0});
                A_SRC_RX:  rdata_d = src_rx_q;
                A_DST_TX:  rdata_d = dst_tx_q;
                A_LEN_RX:  rdata_d = DATA_W'(len_rx_q);
                A_LEN_TX:  rdata_d = DATA_W'(len_tx_q);
                A_STATUS:  rdata_d = DATA_W'({err_tx_q, err_rx_q, done_tx_q, dma_tx_busy,
                                              done_rx_q, dma_rx_busy});
`ifdef DMA_CSR_PERF_EN
                A_PERF_RX: rdata_d = perf_rx_q;
                A_PERF_TX: rdata_d = perf_tx_q;
`endif
                default:   rdata_d = '0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            src_rx_q    <= '0;
            dst_tx_q    <= '0;
            len_rx_q    <= '0;
            len_tx_q    <= '0;
            irq_en_q    <= 1'b0;
            rx_start_q  <= 1'b0;
            tx_start_q  <= 1'b0;
            done_rx_q   <= 1'b0;
            done_tx_q   <= 1'b0;
            err_rx_q    <= 1'b0;
            err_tx_q    <= 1'b0;
            irq_q       <= 1'b0;
            rsp_valid_q <= 1'b0;
            rdata_q     <= '0;
        end else begin
            src_rx_q    <= src_rx_d;
            dst_tx_q    <= dst_tx_d;
            len_rx_q    <= len_rx_d;
            len_tx_q    <= len_tx_d;
            irq_en_q    <= irq_en_d;
            rx_start_q  <= rx_start_d;
            tx_start_q  <= tx_start_d;
            done_rx_q   <= done_rx_d;
            done_tx_q   <= done_tx_d;
            err_rx_q    <= err_rx_d;
            err_tx_q    <= err_tx_d;
            irq_q       <= irq_d;
            rsp_valid_q <= rsp_valid_d;
            rdata_q     <= rdata_d;
        end
    end

`ifdef DMA_CSR_PERF_EN
    // Busy-cycle counters: restart on the start strobe, saturate at all-ones.
    always_comb begin
        perf_rx_d = perf_rx_q;
        perf_tx_d = perf_tx_q;
        if (rx_start_q)                        perf_rx_d = '0;
        else if (dma_rx_busy && ~&perf_rx_q)   perf_rx_d = perf_rx_q + 64'd1;
        if (tx_start_q)                        perf_tx_d = '0;
        else if (dma_tx_busy && ~&perf_tx_q)   perf_tx_d = perf_tx_q + 64'd1;
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            perf_rx_q <= '0;
            perf_tx_q <= '0;
        end else begin
            perf_rx_q <= perf_rx_d;
            perf_tx_q <= perf_tx_d;
        end
    end
`endif

    assign csr_req_ready = 1'b1;
    assign csr_rsp_valid = rsp_valid_q;
    assign csr_rsp_rdata = rdata_q;
    assign dma_rx_src    = src_rx_q;
    assign dma_rx_len    = len_rx_q;
    assign dma_rx_start  = rx_start_q;
    assign dma_tx_dst    = dst_tx_q;
    assign dma_tx_len    = len_tx_q;
    assign dma_tx_start  = tx_start_q;
    assign irq           = irq_q;

endmodule

// File: tb/tb_acc_dma_csr.sv
module tb_acc_dma_csr;

    logic        clk = 1'b0;
    logic        rstn;
    logic        csr_req_valid, csr_req_ready, csr_req_we;
    logic [5:0]  csr_req_addr;
    logic [63:0] csr_req_wdata;
    logic        csr_rsp_valid;
    logic [63:0] csr_rsp_rdata;
    logic [63:0] dma_rx_src, dma_tx_dst;
    logic [31:0] dma_rx_len, dma_tx_len;
    logic        dma_rx_start, dma_rx_busy, dma_rx_done;
    logic        dma_tx_start, dma_tx_busy, dma_tx_done;
    logic        irq;

    int compared   = 0;
    int mismatched = 0;

    always #5 clk = ~clk;

    acc_dma_csr dut (
        .clk(clk), .rstn(rstn),
        .csr_req_valid(csr_req_valid), .csr_req_ready(csr_req_ready),
        .csr_req_we(csr_req_we), .csr_req_addr(csr_req_addr),
        .csr_req_wdata(csr_req_wdata),
        .csr_rsp_valid(csr_rsp_valid), .csr_rsp_rdata(csr_rsp_rdata),
        .dma_rx_src(dma_rx_src), .dma_rx_len(dma_rx_len), .dma_rx_start(dma_rx_start),
        .dma_rx_busy(dma_rx_busy), .dma_rx_done(dma_rx_done),
        .dma_tx_dst(dma_tx_dst), .dma_tx_len(dma_tx_len), .dma_tx_start(dma_tx_start),
        .dma_tx_busy(dma_tx_busy), .dma_tx_done(dma_tx_done),
        .irq(irq)
    );

    typedef struct {
        logic        we;
        logic [5:0]  addr;
        logic [63:0] wdata;
        logic [63:0] exp;
    } vec_t;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // One request; returns at posedge+1 of the response cycle.
    task automatic do_req(input logic we, input logic [5:0] addr, input logic [63:0] wdata,
                          output logic [63:0] rdata);
        @(negedge clk);
        csr_req_valid = 1'b1;
        csr_req_we    = we;
        csr_req_addr  = addr;
        csr_req_wdata = wdata;
        @(posedge clk);
        #1;
        csr_req_valid = 1'b0;
        csr_req_we    = 1'b0;
        chk("rsp_valid", {63'b0, csr_rsp_valid}, 64'd1);
        rdata = csr_rsp_rdata;
    endtask

    task automatic wr(input logic [5:0] addr, input logic [63:0] wdata);
        logic [63:0] d;
        do_req(1'b1, addr, wdata, d);
    endtask

    task automatic rd_chk(input string name, input logic [5:0] addr, input logic [63:0] exp);
        logic [63:0] d;
        do_req(1'b0, addr, 64'd0, d);
        chk(name, d, exp);
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t        vecs[14];
        logic [63:0] d;

        rstn = 1'b0; csr_req_valid = 1'b0; csr_req_we = 1'b0;
        csr_req_addr = '0; csr_req_wdata = '0;
        dma_rx_busy = 0; dma_rx_done = 0; dma_tx_busy = 0; dma_tx_done = 0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_rsp_valid", {63'b0, csr_rsp_valid}, 0);
        chk("rst_irq", {63'b0, irq}, 0);
        chk("rst_starts", {62'b0, dma_rx_start, dma_tx_start}, 0);
        chk("rst_ready", {63'b0, csr_req_ready}, 1);
        chk("rst_src", dma_rx_src, 0);
        chk("rst_len", {dma_rx_len, dma_tx_len}, 0);
        @(negedge clk);
        rstn = 1'b1;
        for (int a = 0; a < 64; a += 8)
            rd_chk("rst_read", 6'(a), 64'd0);

        // Register readback and decode
        vecs[0]  = '{1'b1, 6'h08, 64'h0000_0000_0000_1000, 64'd0};
        vecs[1]  = '{1'b0, 6'h08, 64'd0,                   64'h0000_0000_0000_1000};
        vecs[2]  = '{1'b1, 6'h10, 64'hDEAD_BEEF_0000_1234, 64'd0};
        vecs[3]  = '{1'b0, 6'h10, 64'd0,                   64'hDEAD_BEEF_0000_1234};
        vecs[4]  = '{1'b1, 6'h18, 64'hFFFF_FFFF_0000_0003, 64'd0};
        vecs[5]  = '{1'b0, 6'h18, 64'd0,                   64'h3};
        vecs[6]  = '{1'b1, 6'h20, 64'h3,                   64'd0};
        vecs[7]  = '{1'b0, 6'h20, 64'd0,                   64'h3};
        vecs[8]  = '{1'b1, 6'h00, 64'h100,                 64'd0};
        vecs[9]  = '{1'b0, 6'h00, 64'd0,                   64'h100};
        vecs[10] = '{1'b1, 6'h30, 64'hABC,                 64'd0};
        vecs[11] = '{1'b0, 6'h30, 64'd0,                   64'd0};
        vecs[12] = '{1'b0, 6'h28, 64'd0,                   64'd0};
        vecs[13] = '{1'b0, 6'h08, 64'd0,                   64'h0000_0000_0000_1000};
        for (int i = 0; i < 14; i++) begin
            do_req(vecs[i].we, vecs[i].addr, vecs[i].wdata, d);
            chk($sformatf("vec%0d", i), d, vecs[i].exp);
        end

        // rx start pulse, then a SRC_RX write during the pulse cycle is locked out
        wr(6'h00, 64'h101);
        chk("rx_start_pulse", {62'b0, dma_rx_start, dma_tx_start}, 64'b10);
        chk("rx_src_out", dma_rx_src, 64'h1000);
        chk("rx_len_out", {32'b0, dma_rx_len}, 64'd3);
        wr(6'h08, 64'h7777);
        chk("rx_start_one_cycle", {63'b0, dma_rx_start}, 0);
        rd_chk("src_locked", 6'h08, 64'h1000);
        rd_chk("err_rx_lock", 6'h28, 64'h10);
        idle(1);
        chk("irq_err", {63'b0, irq}, 1);
        wr(6'h28, 64'h10);
        idle(2);
        chk("irq_clr_err", {63'b0, irq}, 0);

        // tx done -> sticky status and irq; W1C; W1C coincident with done
        @(negedge clk); dma_tx_done = 1'b1;
        @(negedge clk); dma_tx_done = 1'b0;
        chk("irq_lag", {63'b0, irq}, 0);
        @(posedge clk); #1;
        chk("irq_done_tx", {63'b0, irq}, 1);
        rd_chk("status_done_tx", 6'h28, 64'h8);
        wr(6'h28, 64'h8);
        idle(1);
        chk("irq_after_w1c", {63'b0, irq}, 0);
        rd_chk("status_cleared", 6'h28, 64'h0);
        @(negedge clk); dma_tx_done = 1'b1;
        @(negedge clk); dma_tx_done = 1'b0;
        @(negedge clk);
        csr_req_valid = 1'b1; csr_req_we = 1'b1; csr_req_addr = 6'h28;
        csr_req_wdata = 64'h8; dma_tx_done = 1'b1;
        @(posedge clk); #1;
        csr_req_valid = 1'b0; csr_req_we = 1'b0; dma_tx_done = 1'b0;
        rd_chk("set_wins_w1c", 6'h28, 64'h8);
        wr(6'h28, 64'h8);
        rd_chk("status_cleared2", 6'h28, 64'h0);

        // tx start refused with LEN_TX=0; DST_TX locked while busy
        wr(6'h20, 64'h0);
        wr(6'h00, 64'h102);
        chk("no_tx_start", {63'b0, dma_tx_start}, 0);
        rd_chk("err_tx_len0", 6'h28, 64'h20);
        wr(6'h28, 64'h20);
        @(negedge clk); dma_tx_busy = 1'b1;
        wr(6'h10, 64'h2000);
        chk("dst_out_locked", dma_tx_dst, 64'hDEAD_BEEF_0000_1234);
        rd_chk("dst_locked", 6'h10, 64'hDEAD_BEEF_0000_1234);
        rd_chk("err_tx_busy", 6'h28, 64'h24);
        @(negedge clk); dma_tx_busy = 1'b0;
        wr(6'h28, 64'h20);

        // Both directions start together; reset while busy
        wr(6'h20, 64'h3);
        wr(6'h00, 64'h103);
        chk("both_start", {62'b0, dma_rx_start, dma_tx_start}, 64'b11);
        @(negedge clk); dma_rx_busy = 1'b1; dma_tx_busy = 1'b1; dma_rx_done = 1'b1;
        @(negedge clk); dma_rx_done = 1'b0;
        wr(6'h00, 64'h101);
        rd_chk("status_busy", 6'h28, 64'h17);
        idle(1);
        chk("irq_busy", {63'b0, irq}, 1);
        @(negedge clk); rstn = 1'b0; dma_tx_done = 1'b1;
        @(negedge clk); dma_tx_done = 1'b0;
        @(negedge clk); rstn = 1'b1;
        chk("irq_after_rst", {63'b0, irq}, 0);
        chk("src_after_rst", dma_rx_src, 0);
        rd_chk("status_after_rst", 6'h28, 64'h5);
        rd_chk("ctrl_after_rst", 6'h00, 64'h0);
        @(negedge clk); dma_rx_busy = 1'b0; dma_tx_busy = 1'b0;
        rd_chk("status_idle", 6'h28, 64'h0);

`ifdef DMA_CSR_PERF_EN
        wr(6'h18, 64'h3);
        wr(6'h00, 64'h1);
        chk("perf_start", {63'b0, dma_rx_start}, 1);
        @(posedge clk);
        @(negedge clk); dma_rx_busy = 1'b1;
        repeat (10) @(negedge clk);
        dma_rx_busy = 1'b0;
        rd_chk("perf_rx", 6'h30, 64'd10);
        rd_chk("perf_tx", 6'h38, 64'd0);
`else
        rd_chk("perf_rx_unmapped", 6'h30, 64'd0);
        rd_chk("perf_tx_unmapped", 6'h38, 64'd0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
